array_stack_unit: RTL
=====================

# array_stack_unit

Hardware engine for multiple bounded stacks (arrays) held in one on-chip heap. It provides alloc/free/push/pop commands over a valid/ready command channel and a valid/ready response channel. Freed array indices are recycled through an internal free-list stack, and overflow, underflow, exhaustion and bad-index conditions are reported as error codes. It replaces the unrolled per-program array logic in FPGA test harnesses with one reusable parametrised block.

## Interface
- WIDTH, 12, heap element / data width
- N_ARRAYS, 4, maximum simultaneously allocated arrays
- N_AREA, 4, capacity (elements) of each array
- Derived: AW = max(1,$clog2(N_ARRAYS)); SW = $clog2(N_AREA+1); heap depth N_ARRAYS*N_AREA

Ports:
- clock  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd_op  in  2  00 ALLOC, 01 FREE, 10 PUSH, 11 POP
- cmd_array  in  AW  target array (FREE/PUSH/POP)
- cmd_data  in  WIDTH  value to push
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_data  out  WIDTH  result
- rsp_error  out  3  0 OK, 1 NOMEM, 2 BADARR, 3 FULL, 4 EMPTY
- in_use  out  AW+1  arrays currently allocated
- max_in_use  out  AW+1  high-water mark of in_use since reset

## Operation
- State:
  - size[N_ARRAYS] (SW bits each)
  - alloc bitmap
  - free stack (N_ARRAYS entries, pointer 0..N_ARRAYS)
  - fresh counter (0..N_ARRAYS)
  - single-port sync heap RAM
- FSM: IDLE -> EXEC -> RESP -> IDLE.
  - cmd_ready = (state==IDLE) && !reset.
  - Handshake completes when cmd_valid && cmd_ready.
- ALLOC:
  - If the free stack is non-empty, pop it; else if fresh<N_ARRAYS, take fresh and increment fresh; else NOMEM.
  - On success: size[idx]=0, alloc[idx]=1, rsp_data=idx.
- FREE:
  - cmd_array not allocated -> BADARR.
  - Otherwise push the index onto the free stack, clear alloc, rsp_data=0.
- PUSH:
  - Unallocated -> BADARR; size==N_AREA -> FULL.
  - Otherwise write heap[array*N_AREA+size]=cmd_data, size++, rsp_data=new size.
- POP:
  - Unallocated -> BADARR; size==0 -> EMPTY.
  - Otherwise size--, read heap[array*N_AREA+size-1], rsp_data=read value.
- Any error leaves all state unchanged and sets rsp_data=0.
- Out-of-range cmd_array (>=N_ARRAYS) -> BADARR.
- in_use increments on a successful ALLOC and decrements on a successful FREE. max_in_use updates in the same cycle as in_use.
- Size arithmetic is unsigned SW-bit. Heap address is computed in $clog2(N_ARRAYS*N_AREA) bits with no wrap; legal indices never overflow.

## Timing
- Reset values:
  - cmd_ready=0 while reset is high, 1 in the first cycle after.
  - rsp_valid=0, rsp_data=0, rsp_error=0, in_use=0, max_in_use=0.
  - All sizes 0, bitmap 0, free stack empty, fresh=0.
  - Heap contents are not cleared.
- Cycle 0: command accepted, operands registered.
- Cycle 1 (EXEC): error checks, state updates, heap write or heap read issued.
- Cycle 2: rsp_valid=1, held with rsp_data/rsp_error stable until rsp_ready.
- Response leaves on the cycle rsp_valid && rsp_ready. The next command can be accepted the following cycle.
- Latency is 2 cycles; peak throughput is 1 command per 3 cycles.
- rsp_ready stalls hold RESP indefinitely; cmd_ready stays 0 throughout.
- Reset mid-operation aborts the in-flight command with no response and no partial state. Heap writes already performed are harmless.
- A FREE followed immediately by ALLOC returns the just-freed index (LIFO recycling).

## Structure
- Package array_stack_pkg:
  - op enum (OP_ALLOC, OP_FREE, OP_PUSH, OP_POP)
  - err enum (ERR_OK, ERR_NOMEM, ERR_BADARR, ERR_FULL, ERR_EMPTY)
  - FSM state enum
- Sub-module array_stack_heap_ram:
  - Single-port synchronous RAM, parametrised width/depth.
  - One-cycle read, write-enable.
  - Inferable as block RAM.

## Test plan
- ALLOC; PUSH 1; PUSH 2; POP; POP -> rsp_data 0, 1, 2, 2, 1; all OK; in_use=1.
- ALLOC then POP on the empty array -> EMPTY, rsp_data 0, size unchanged.
- N_AREA=4: five PUSHes of 7 -> sizes 1..4 OK, fifth FULL; then POP returns 7.
- Four ALLOCs -> 0,1,2,3; fifth -> NOMEM; FREE 2; ALLOC -> 2; max_in_use=4.
- FREE 1 twice -> OK then BADARR; PUSH to array 1 -> BADARR.
- Hold rsp_ready=0 for 5 cycles after a POP -> response stable, cmd_ready=0. Then assert reset during EXEC of a PUSH -> no response, all outputs return to their reset values.

Source files
------------

// File: rtl/array_stack_pkg.sv
// array_stack_pkg
//   Shared types for the array stack engine: command opcodes, response
//   error codes and the control FSM state encoding.
package array_stack_pkg;

  typedef enum logic [1:0] {
    OP_ALLOC = 2'b00,
    OP_FREE  = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ERR_OK     = 3'd0,
    ERR_NOMEM  = 3'd1,
    ERR_BADARR = 3'd2,
    ERR_FULL   = 3'd3,
    ERR_EMPTY  = 3'd4
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/array_stack_heap_ram.sv
// array_stack_heap_ram
//   Single-port synchronous RAM backing the stack heap. One access per
//   cycle: a write when i_we is set, otherwise a read whose data appears on
//   o_rdata the following cycle and is held until the next read.
// Ports:
//   clock    clock, posedge
//   i_en     access enable
//   i_we     write enable (qualified by i_en)
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data
module array_stack_heap_ram #(
  parameter int WIDTH  = 12,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: neither the array nor the read register has a reset; a reset port
  // would stop the array mapping onto block RAM.
  always_ff @(posedge clock) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/array_stack_unit.sv
// array_stack_unit
//   Multiple bounded stacks held in one heap RAM. Commands (ALLOC, FREE,
//   PUSH, POP) are taken over a valid/ready channel, executed in one cycle
//   and answered over a valid/ready response channel two cycles later.
//   Freed array indices are recycled LIFO through a small free-list stack.
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_op                  00 ALLOC, 01 FREE, 10 PUSH, 11 POP
//   cmd_array, cmd_data     target array and value to push
//   rsp_valid/rsp_ready     response handshake
//   rsp_data, rsp_error     result and error code
//   in_use, max_in_use      live array count and its high-water mark
module array_stack_unit
  import array_stack_pkg::*;
#(
  parameter  int WIDTH    = 12,
  parameter  int N_ARRAYS = 4,
  parameter  int N_AREA   = 4,
  localparam int AW       = (N_ARRAYS <= 1) ? 1 : $clog2(N_ARRAYS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_array,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_error,
  output logic [AW:0]      in_use,
  output logic [AW:0]      max_in_use
);

  localparam int SW  = $clog2(N_AREA + 1);
  localparam int FW  = $clog2(N_ARRAYS + 1);
  localparam int HD  = N_ARRAYS * N_AREA;
  localparam int HAW = (HD <= 1) ? 1 : $clog2(HD);

  state_e           r_state, w_state_next;
  op_e              r_op;
  logic [AW-1:0]    r_array;
  logic [WIDTH-1:0] r_data;

  logic [SW-1:0]    r_size [N_ARRAYS];
  logic [N_ARRAYS-1:0] r_alloc;
  logic [AW-1:0]    r_free_stack [N_ARRAYS];
  logic [FW-1:0]    r_free_ptr;
  logic [FW-1:0]    r_fresh;
  logic [AW:0]      r_in_use, r_max_in_use;

  err_e             r_rsp_error;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_from_ram;

  logic             w_accept, w_exec, w_in_range, w_arr_ok;
  logic [SW-1:0]    w_cur_size, w_size_inc, w_size_dec;
  logic [HAW-1:0]   w_base;
  logic [AW-1:0]    w_free_top, w_fresh_idx;
  logic [AW:0]      w_in_use_inc;

  err_e             w_err;
  logic [WIDTH-1:0] w_rsp_data;
  logic             w_ram_en, w_ram_we;
  logic [HAW-1:0]   w_ram_addr;
  logic [AW-1:0]    w_alloc_idx;
  logic             w_from_free;
  logic             w_do_free;
  logic [WIDTH-1:0] w_ram_rdata;

  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_exec    = (r_state == ST_EXEC);

  // Operand decode for the command held in EXEC.
  assign w_in_range   = ({1'b0, r_array} < (AW+1)'(N_ARRAYS));
  assign w_arr_ok     = w_in_range && r_alloc[r_array];
  assign w_cur_size   = r_size[r_array];
  assign w_size_inc   = w_cur_size + 1'b1;
  assign w_size_dec   = w_cur_size - 1'b1;
  assign w_base       = HAW'(r_array) * HAW'(N_AREA);
  assign w_free_top   = AW'(r_free_ptr - 1'b1);
  assign w_fresh_idx  = AW'(r_fresh);
  assign w_in_use_inc = r_in_use + 1'b1;

  // Error checks and heap access for the command in EXEC.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // one unassigned, which would infer a latch.
    w_err       = ERR_OK;
    w_rsp_data  = '0;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = w_base + HAW'(w_cur_size);
    w_alloc_idx = '0;
    w_from_free = 1'b0;
    case (r_op)
      OP_ALLOC: begin
        if (r_free_ptr != '0) begin
          w_from_free = 1'b1;
          w_alloc_idx = r_free_stack[w_free_top];
          w_rsp_data  = WIDTH'(w_alloc_idx);
        end else if (r_fresh < FW'(N_ARRAYS)) begin
          w_alloc_idx = w_fresh_idx;
          w_rsp_data  = WIDTH'(w_alloc_idx);
        end else begin
          w_err = ERR_NOMEM;
        end
      end
      OP_FREE: begin
        if (!w_arr_ok) w_err = ERR_BADARR;
      end
      OP_PUSH: begin
        if (!w_arr_ok) begin
          w_err = ERR_BADARR;
        end else if (w_cur_size == SW'(N_AREA)) begin
          w_err = ERR_FULL;
        end else begin
          w_ram_en   = 1'b1;
          w_ram_we   = 1'b1;
          w_rsp_data = WIDTH'(w_size_inc);
        end
      end
      OP_POP: begin
        if (!w_arr_ok) begin
          w_err = ERR_BADARR;
        end else if (w_cur_size == '0) begin
          w_err = ERR_EMPTY;
        end else begin
          w_ram_en   = 1'b1;
          w_ram_addr = w_base + HAW'(w_size_dec);
        end
      end
      default: w_err = ERR_OK;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_EXEC;
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Operand and free-list entry storage need no reset: they are only read
  // after being written (operands in EXEC, entries below the stack pointer).
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_op    <= op_e'(cmd_op);
      r_array <= cmd_array;
      r_data  <= cmd_data;
    end
  end

  assign w_do_free = w_exec && !reset && (r_op == OP_FREE) && (w_err == ERR_OK);

  always_ff @(posedge clock) begin
    if (w_do_free) r_free_stack[AW'(r_free_ptr)] <= r_array;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_ARRAYS; i++) r_size[i] <= '0;
      r_alloc        <= '0;
      r_free_ptr     <= '0;
      r_fresh        <= '0;
      r_in_use       <= '0;
      r_max_in_use   <= '0;
      r_rsp_error    <= ERR_OK;
      r_rsp_data     <= '0;
      r_rsp_from_ram <= 1'b0;
    end else if (w_exec) begin
      r_rsp_error    <= w_err;
      r_rsp_data     <= w_rsp_data;
      // A successful POP takes its data straight from the RAM read port.
      r_rsp_from_ram <= (r_op == OP_POP) && (w_err == ERR_OK);
      if (w_err == ERR_OK) begin
        case (r_op)
          OP_ALLOC: begin
            r_size[w_alloc_idx]  <= '0;
            r_alloc[w_alloc_idx] <= 1'b1;
            if (w_from_free) r_free_ptr <= r_free_ptr - 1'b1;
            else             r_fresh    <= r_fresh + 1'b1;
            r_in_use <= w_in_use_inc;
            if (w_in_use_inc > r_max_in_use) r_max_in_use <= w_in_use_inc;
          end
          OP_FREE: begin
            r_alloc[r_array] <= 1'b0;
            r_free_ptr       <= r_free_ptr + 1'b1;
            r_in_use         <= r_in_use - 1'b1;
          end
          OP_PUSH: r_size[r_array] <= w_size_inc;
          OP_POP:  r_size[r_array] <= w_size_dec;
          default: ;
        endcase
      end
    end
  end

  array_stack_heap_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (HD),
    .ADDR_W (HAW)
  ) u_heap (
    .clock   (clock),
    .i_en    (w_exec && w_ram_en && !reset),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_data),
    .o_rdata (w_ram_rdata)
  );

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_data   = r_rsp_from_ram ? w_ram_rdata : r_rsp_data;
  assign rsp_error  = r_rsp_error;
  assign in_use     = r_in_use;
  assign max_in_use = r_max_in_use;

endmodule
